// File: rtl/rr_channel_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_channel_arbiter_pkg
//   Shared definitions for the four-channel round-robin arbiter:
//   channel count, channel index constants, the output-stage state type
//   and the round-robin winner search.
// -----------------------------------------------------------------------------
package rr_channel_arbiter_pkg;

   localparam int NUM_CH = 4;

   typedef logic [1:0] ch_idx_t;

   localparam ch_idx_t CH_A = 2'd0;
   localparam ch_idx_t CH_B = 2'd1;
   localparam ch_idx_t CH_C = 2'd2;
   localparam ch_idx_t CH_D = 2'd3;

   // Output stage condition, decoded from out_valid/out_ready each cycle.
   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FULL_DRAINING,
      ST_FULL_STALLED
   } arb_state_t;

   // Returns the first requesting channel found when scanning upward from
   // last+1 with wrap-around. The request vector is rotated so that bit 0
   // corresponds to channel last+1; the lowest set bit of the rotated
   // vector wins. When req is all zero the result is last (caller ignores it).
   function automatic ch_idx_t rr_pick(input logic [NUM_CH-1:0] req,
                                       input ch_idx_t           last);
      logic [2*NUM_CH-1:0] dbl;
      logic [NUM_CH-1:0]   rot;
      ch_idx_t             win;
      dbl = {req, req};
      rot = NUM_CH'(dbl >> (3'(last) + 3'd1));
      win = last;
      // Scan from the top down so the lowest set bit is the last one written.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (rot[i]) win = last + ch_idx_t'(i) + 2'd1;
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_channel_arbiter_mux.sv
// -----------------------------------------------------------------------------
// rr_channel_arbiter_mux
//   4:1 data multiplexer used on the arbiter data path.
//   Ports:
//     sel  in   2           channel select
//     a..d in   DATA_WIDTH  channel words 0..3
//     y    out  DATA_WIDTH  selected word
// -----------------------------------------------------------------------------
module rr_channel_arbiter_mux
   import rr_channel_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [1:0]            sel,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [DATA_WIDTH-1:0] c,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] y
);

   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven,
      // so no latch can be inferred even if the case list is later edited.
      y = a;
      case (sel)
         CH_A:    y = a;
         CH_B:    y = b;
         CH_C:    y = c;
         CH_D:    y = d;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/rr_channel_arbiter.sv
// -----------------------------------------------------------------------------
// rr_channel_arbiter
//   Round-robin arbiter over four producer channels feeding a single-entry
//   valid/ready output register. Sustains one word per cycle when the
//   consumer is ready; stalls all grants when the output is full and held.
//   Ports:
//     clk        in   1           rising-edge clock
//     rst        in   1           asynchronous active-high reset
//     req        in   4           per-channel valid (bit0=a .. bit3=d)
//     a..d       in   DATA_WIDTH  channel words, stable while requesting
//     gnt        out  4           one-hot accept pulse (word consumed now)
//     select     out  2           channel currently steering the mux
//     out_data   out  DATA_WIDTH  registered word
//     out_chan   out  2           source channel of out_data
//     out_valid  out  1           out_data holds an unconsumed word
//     out_ready  in   1           consumer takes out_data this cycle
// -----------------------------------------------------------------------------
module rr_channel_arbiter
   import rr_channel_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     req,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [DATA_WIDTH-1:0] c,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [NUM_CH-1:0]     gnt,
   output logic [1:0]            select,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            out_chan,
   output logic                  out_valid,
   input  logic                  out_ready
);

   ch_idx_t               last_ptr;
   ch_idx_t               win_idx;
   logic                  win_vld;
   logic                  can_load;
   logic                  grant;
   arb_state_t            arb_state;
   logic [DATA_WIDTH-1:0] mux_out;

   always_comb begin
      arb_state = ST_EMPTY;
      if (out_valid) arb_state = out_ready ? ST_FULL_DRAINING : ST_FULL_STALLED;

      can_load = (arb_state != ST_FULL_STALLED);
      win_vld  = |req;
      win_idx  = rr_pick(req, last_ptr);
      // Gated by rst so the accept pulse is also cleared asynchronously.
      grant    = win_vld && can_load && !rst;
      select   = win_vld ? win_idx : last_ptr;

      gnt = '0;
      if (grant) gnt[win_idx] = 1'b1;
   end

   rr_channel_arbiter_mux #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mux (
      .sel (select),
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .y   (mux_out)
   );

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= CH_A;
         last_ptr  <= CH_D;   // channel 0 gets first priority after reset
      end else if (grant) begin
         out_data  <= mux_out;
         out_chan  <= win_idx;
         out_valid <= 1'b1;
         last_ptr  <= win_idx;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;   // drain only; out_data keeps its last value
      end
   end

endmodule

// File: tb/tb_rr_channel_arbiter.sv
module tb_rr_channel_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [7:0] a, b, c, d;
   logic [3:0] gnt;
   logic [1:0] select;
   logic [7:0] out_data;
   logic [1:0] out_chan;
   logic       out_valid;
   logic       out_ready;

   int total = 0;
   int bad   = 0;

   rr_channel_arbiter #(.DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .gnt       (gnt),
      .select    (select),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   int         m_last;
   logic       m_valid;
   logic [7:0] m_data;
   int         m_chan;

   function automatic int model_winner(input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(m_last + k) % 4]) return (m_last + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_gnt(input logic [3:0] r, input logic rdy);
      int w;
      if (m_valid && !rdy) return 4'b0000;
      w = model_winner(r);
      if (w < 0) return 4'b0000;
      return 4'b0001 << w;
   endfunction

   function automatic int model_select(input logic [3:0] r);
      int w;
      w = model_winner(r);
      return (w < 0) ? m_last : w;
   endfunction

   task automatic model_reset();
      m_last  = 3;
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_chan  = 0;
   endtask

   task automatic model_step(input logic [3:0] r, input logic rdy);
      logic [7:0] words [4];
      int w;
      words[0] = a; words[1] = b; words[2] = c; words[3] = d;
      if (model_gnt(r, rdy) != 4'b0000) begin
         w       = model_winner(r);
         m_data  = words[w];
         m_chan  = w;
         m_valid = 1'b1;
         m_last  = w;
      end else if (rdy && m_valid) begin
         m_valid = 1'b0;
      end
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle: apply inputs, sample combinational outputs, advance the
   // model and the DUT across one rising edge, end 1 time unit after it.
   task automatic apply(input logic [3:0] r, input logic rdy,
                        output logic [3:0] g_seen, output logic [1:0] s_seen,
                        output logic [3:0] g_exp,  output logic [1:0] s_exp);
      req       = r;
      out_ready = rdy;
      #1;
      g_seen = gnt;
      s_seen = select;
      g_exp  = model_gnt(r, rdy);
      s_exp  = 2'(model_select(r));
      model_step(r, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic [3:0] req;
      logic       rdy;
      logic [3:0] gnt;
      logic       vld;
      logic [7:0] dat;
      logic [1:0] chan;
   } vec_t;

   vec_t tbl [9];

   logic [3:0] g_seen, g_exp, r_cur;
   logic [1:0] s_seen, s_exp;
   int         waits [4];

   initial begin
      tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
      tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
      tbl[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
      tbl[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
      tbl[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
      tbl[5] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
      tbl[6] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
      tbl[7] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
      tbl[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd3};

      req = 4'b0000; out_ready = 1'b1;
      a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
      rst = 1'b0;
      #2;
      do_reset();
      check("reset_valid", {31'd0, out_valid}, 0);
      check("reset_data", {24'd0, out_data}, 0);

      // Asynchronous reset while holding a word.
      apply(4'b0001, 1'b1, g_seen, s_seen, g_exp, s_exp);
      check("pre_reset_valid", {31'd0, out_valid}, 1);
      rst = 1'b1;
      #1;
      check("async_valid", {31'd0, out_valid}, 0);
      check("async_gnt", {28'd0, gnt}, 0);
      check("async_data", {24'd0, out_data}, 0);
      check("async_chan", {30'd0, out_chan}, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Rotation, wrap-around with sparse requests, drain-only.
      foreach (tbl[i]) begin
         apply(tbl[i].req, tbl[i].rdy, g_seen, s_seen, g_exp, s_exp);
         check($sformatf("tbl%0d_gnt", i),  {28'd0, g_seen},    {28'd0, tbl[i].gnt});
         check($sformatf("tbl%0d_vld", i),  {31'd0, out_valid}, {31'd0, tbl[i].vld});
         check($sformatf("tbl%0d_data", i), {24'd0, out_data},  {24'd0, tbl[i].dat});
         check($sformatf("tbl%0d_chan", i), {30'd0, out_chan},  {30'd0, tbl[i].chan});
      end

      // Backpressure: load b, stall 5 cycles, then same-cycle reload with c.
      do_reset();
      apply(4'b0110, 1'b0, g_seen, s_seen, g_exp, s_exp);
      check("bp_first_gnt", {28'd0, g_seen}, 32'b0010);
      for (int i = 0; i < 5; i++) begin
         apply(4'b0110, 1'b0, g_seen, s_seen, g_exp, s_exp);
         check("bp_stall_gnt", {28'd0, g_seen}, 0);
         check("bp_stall_valid", {31'd0, out_valid}, 1);
         check("bp_stall_data", {24'd0, out_data}, 32'h22);
      end
      apply(4'b0110, 1'b1, g_seen, s_seen, g_exp, s_exp);
      check("bp_release_gnt", {28'd0, g_seen}, 32'b0100);
      check("bp_reload_data", {24'd0, out_data}, 32'h33);
      check("bp_reload_valid", {31'd0, out_valid}, 1);

      // Single requester at full rate.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         apply(4'b0100, 1'b1, g_seen, s_seen, g_exp, s_exp);
         check("single_gnt", {28'd0, g_seen}, 32'b0100);
         check("single_valid", {31'd0, out_valid}, 1);
      end

      // Randomized traffic against the model, with protocol-respecting
      // producers (request and data held until granted, rare withdrawals).
      do_reset();
      r_cur = 4'b0000;
      for (int ch = 0; ch < 4; ch++) waits[ch] = 0;
      for (int i = 0; i < 400; i++) begin
         for (int ch = 0; ch < 4; ch++) begin
            if (!r_cur[ch] && ($urandom_range(0, 2) == 0)) begin
               r_cur[ch] = 1'b1;
               case (ch)
                  0: a = 8'($urandom);
                  1: b = 8'($urandom);
                  2: c = 8'($urandom);
                  default: d = 8'($urandom);
               endcase
            end else if (r_cur[ch] && ($urandom_range(0, 15) == 0)) begin
               r_cur[ch] = 1'b0;
               waits[ch] = 0;
            end
         end
         apply(r_cur, 1'($urandom_range(0, 3) != 0), g_seen, s_seen, g_exp, s_exp);
         check("rnd_gnt", {28'd0, g_seen}, {28'd0, g_exp});
         check("rnd_sel", {30'd0, s_seen}, {30'd0, s_exp});
         check("rnd_valid", {31'd0, out_valid}, {31'd0, m_valid});
         check("rnd_data", {24'd0, out_data}, {24'd0, m_data});
         check("rnd_chan", {30'd0, out_chan}, 32'(m_chan));
         if (g_exp != 4'b0000) begin
            for (int ch = 0; ch < 4; ch++) begin
               if (g_exp[ch]) waits[ch] = 0;
               else if (r_cur[ch]) waits[ch]++;
               check("rnd_fair", 32'(waits[ch] > 3), 0);
            end
         end
         r_cur = r_cur & ~g_seen;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_channel_arbiter.md
Name: rr_channel_arbiter

Overview:
- Sits directly upstream of the 4:1 data multiplexer. It arbitrates four requesting channels (a, b, c, d) with round-robin fairness.
- Drives the 2-bit channel select into its own instance of the team's 4:1 multiplexer. It registers the selected word into a single-entry output stage with a valid/ready handshake.
- Gives a shared downstream consumer fair, lossless access to four producers.

Parameters:
- DATA_WIDTH, 8, width of each channel word and of the output word.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-channel valid; bit0=a, bit1=b, bit2=c, bit3=d.
- a  input  DATA_WIDTH  channel 0 data, held stable while req[0]=1.
- b  input  DATA_WIDTH  channel 1 data.
- c  input  DATA_WIDTH  channel 2 data.
- d  input  DATA_WIDTH  channel 3 data.
- gnt  output  4  one-hot accept pulse; the channel's word is consumed in this cycle.
- select  output  2  channel currently driving the mux (combinational grant index).
- out_data  output  DATA_WIDTH  registered word.
- out_chan  output  2  channel index of out_data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high.
  - Reset values: gnt=0, out_valid=0, out_data=0, out_chan=0, last_ptr=3.
  - With last_ptr=3, channel 0 has first priority.
- Output register capacity: 1 word.
  - can_load = !out_valid || out_ready.
  - Load and drain in the same cycle is allowed, giving full throughput of 1 word/cycle.
- Arbitration (combinational, evaluated every cycle):
  - Search req starting at (last_ptr+1) mod 4, wrapping 3→0.
  - The first set bit is win_idx; win_vld = |req.
- select = win_idx when win_vld, else last_ptr.
  - select feeds the embedded Mux.
  - The mux output is the word captured.
- gnt[win_idx] = win_vld && can_load, combinational, one-hot or zero.
- On a clock edge with grant:
  - out_data <= mux output.
  - out_chan <= win_idx.
  - out_valid <= 1.
  - last_ptr <= win_idx.
- On a clock edge with out_ready && out_valid and no grant: out_valid <= 0.
- Latency: request to out_valid is 1 cycle when can_load.
- Backpressure: out_valid=1 and out_ready=0 gives gnt=0.
  - last_ptr holds.
  - out_data and out_chan hold stable.
  - Producers must keep req and data stable until their gnt bit pulses.
- Arbiter states (derived from out_valid; no separate FSM register is needed):
  - EMPTY (out_valid=0): grant any winner.
  - FULL_DRAINING (out_valid=1, out_ready=1): grant and reload.
  - FULL_STALLED (out_valid=1, out_ready=0): no grant.
- Fairness:
  - Any continuously asserted req is granted within 4 grants.
  - The same channel is never granted twice in a row while another req is pending.
- A single requester is granted every cycle it requests, with no idle gap.
- req deasserted without gnt: the channel is dropped from arbitration; no state is changed.
- Reset mid-transfer: the pending word is discarded, out_valid goes 0 immediately (async), and the pointer returns to 3.
- No X propagation: out_data changes only on grant.

Decomposition:
- Shared package/header:
  - channel index constants CH_A=2'd0, CH_B=2'd1, CH_C=2'd2, CH_D=2'd3;
  - NUM_CH=4.
- One sub-module: instantiate the existing 4:1 Mux (DATA_WIDTH passed through) for the data path.
- Round-robin winner search stays inline as a function over the rotated req vector.

Test Plan:
1. Reset check: assert rst mid-run with out_valid=1 → out_valid, gnt, out_data and out_chan read 0 asynchronously. After release, req=4'b1111 → first gnt=4'b0001.
2. Round-robin rotation: req=4'b1111 held, out_ready=1, a=8'h11, b=8'h22, c=8'h33, d=8'h44 → gnt sequence 0001, 0010, 0100, 1000, 0001. out_data one cycle later reads 11, 22, 33, 44, 11 with out_chan 0, 1, 2, 3, 0.
3. Backpressure: out_ready=0 after first load with req=4'b0110 → out_valid=1, out_data=8'h22 stable, gnt=0 for 5 cycles. Raise out_ready → next gnt=4'b0100, same-cycle reload, out_data=8'h33.
4. Wrap-around and sparse requests: last grant ch3, req=4'b1001 → next gnt=4'b0001, then 4'b1000.
5. Single requester at full rate: req=4'b0100 continuous, out_ready=1 → gnt[2]=1 every cycle and out_valid stays 1 with no bubbles.
6. Drain-only: out_valid=1, req=0, out_ready=1 → out_valid=0 next cycle and out_data unchanged.
